// File: rtl/spi_pkg.sv
// Shared SPI constants and FSM state encodings.
// Used by the SPI read master and the SPI write master.
package spi_pkg;

  localparam int SPI_CLK_DIV = 4;
  localparam int SPI_CMD_W   = 8;
  localparam int SPI_DATA_W  = 8;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t SETUP = 3'd1;
  localparam state_t CMD   = 3'd2;
  localparam state_t DATA  = 3'd3;
  localparam state_t HOLD  = 3'd4;
  localparam state_t DONE  = 3'd5;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: tick pulses every N clk cycles while clr=0.
// Ports: clk, rst_l (async, active-low), clr (restart), tick (1-cycle pulse).
module spi_tick_gen
  import spi_pkg::*;
#(
  parameter int N = SPI_CLK_DIV
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(N + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = !clr && (cnt_q == W'(N - 1));

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_read_master.sv
// SPI mode-0 read master: shifts out a command byte, then reads a data byte.
// Ports: start/cmd in, busy/done/rdata out, sclk/cs_n/mosi/miso SPI side.
module spi_read_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV,
  parameter int CMD_W   = SPI_CMD_W,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              start,
  input  logic [CMD_W-1:0]  cmd,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int MAXW = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int BW   = $clog2(MAXW) + 1;

  state_t            state_q, state_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [CMD_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;
  logic              tick_clr;

  // Counter only runs inside a transfer, so SETUP starts a fresh half-period.
  assign tick_clr = (state_q == IDLE) || (state_q == DONE);

  spi_tick_gen #(
    .N(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_l(rst_l),
    .clr  (tick_clr),
    .tick (tick)
  );

  // mosi is the shift register MSB; it is cleared on entry to DATA.
  assign mosi  = shift_q[CMD_W-1];
  assign sclk  = sclk_q;
  assign cs_n  = cs_n_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        cs_n_d = 1'b1;
        busy_d = 1'b0;
        sclk_d = 1'b0;
        if (start) begin
          state_d = SETUP;
          shift_d = cmd;
          rx_d    = '0;
          bit_d   = '0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = CMD;
          sclk_d  = 1'b1;
          bit_d   = '0;
        end
      end
      CMD: begin
        if (tick && sclk_q) begin
          sclk_d = 1'b0;
          if (bit_q != BW'(CMD_W - 1)) begin
            shift_d = {shift_q[CMD_W-2:0], 1'b0};
          end
        end else if (tick) begin
          sclk_d = 1'b1;
          if (bit_q == BW'(CMD_W - 1)) begin
            state_d = DATA;
            shift_d = '0;
            bit_d   = '0;
            rx_d    = {rx_q[DATA_W-2:0], miso};
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      DATA: begin
        if (tick && sclk_q) begin
          sclk_d = 1'b0;
        end else if (tick) begin
          if (bit_q == BW'(DATA_W - 1)) begin
            state_d = HOLD;
          end else begin
            sclk_d = 1'b1;
            bit_d  = bit_q + BW'(1);
            rx_d   = {rx_q[DATA_W-2:0], miso};
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = DONE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rdata_d = rx_q;
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
        sclk_d  = 1'b0;
        shift_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_read_master.sv
// Bench for spi_read_master: timeline model, SPI slave model, directed
// and randomized transfers, plus a CLK_DIV=2 instance.
module tb_spi_read_master;

  localparam int D  = 4;
  localparam int CW = 8;
  localparam int DW = 8;
  localparam int TD = 1 + (2 + 2 * (CW + DW)) * D;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       start;
  logic [7:0] cmd;
  logic       busy, done, sclk, cs_n, mosi;
  logic [7:0] rdata;
  logic       miso = 1'b0;

  logic       start2;
  logic [7:0] cmd2;
  logic       busy2, done2, sclk2, cs_n2, mosi2;
  logic [7:0] rdata2;

  always #5 clk = ~clk;

  spi_read_master dut (
    .clk  (clk),
    .rst_l(rst_l),
    .start(start),
    .cmd  (cmd),
    .busy (busy),
    .done (done),
    .rdata(rdata),
    .sclk (sclk),
    .cs_n (cs_n),
    .mosi (mosi),
    .miso (miso)
  );

  spi_read_master #(
    .CLK_DIV(2)
  ) dut2 (
    .clk  (clk),
    .rst_l(rst_l),
    .start(start2),
    .cmd  (cmd2),
    .busy (busy2),
    .done (done2),
    .rdata(rdata2),
    .sclk (sclk2),
    .cs_n (cs_n2),
    .mosi (mosi2),
    .miso (1'b1)
  );

  int nvec = 0;
  int nbad = 0;
  int cyc  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected {cs_n,sclk,mosi,busy,done} k cycles after acceptance.
  function automatic logic [4:0] model_out(input int k, input logic [7:0] c);
    int  j, h, b;
    logic s, m;
    if (k <= D) return {1'b0, 1'b0, c[7], 1'b1, 1'b0};
    if (k <= D + 2 * (CW + DW) * D) begin
      j = k - D - 1;
      h = j / D;
      b = h / 2;
      s = (h % 2 == 0);
      if (b >= CW) m = 1'b0;
      else if (s) m = c[CW-1-b];
      else if (b < CW - 1) m = c[CW-2-b];
      else m = c[0];
      return {1'b0, s, m, 1'b1, 1'b0};
    end
    if (k < TD) return 5'b00010;
    return 5'b10001;
  endfunction

  logic       active = 1'b0;
  int         t0 = -100000;
  logic [7:0] cmd_m = 8'h00;

  always @(posedge clk) begin
    if (!rst_l) begin
      active = 1'b0;
    end else begin
      if (active && (cyc - t0 == TD)) active = 1'b0;
      if (!active && start) begin
        active = 1'b1;
        t0     = cyc;
        cmd_m  = cmd;
      end
    end
    cyc++;
  end

  logic [7:0] next_byte = 8'h00;
  logic [7:0] sbyte = 8'h00;
  logic [7:0] rdata_exp = 8'h00;
  logic [7:0] mosi_cap = 8'h00;
  logic [7:0] mosi_at_done = 8'h00;
  logic       prev_sclk = 1'b0;
  int         srises = 0;
  int         rises_at_done = 0;
  int         ndone = 0;
  int         done_cyc = 0;
  int         done_run = 0;
  int         done_wide = 0;
  int         cs_run = 0;
  int         last_cs_run = 0;

  always @(negedge clk) begin
    logic [12:0] got, exp;
    logic [4:0]  e;
    int          k;
    got = {cs_n, sclk, mosi, busy, done, rdata};
    if (!rst_l) begin
      rdata_exp = 8'h00;
      exp = {5'b10000, 8'h00};
    end else if (active) begin
      k = cyc - t0;
      e = model_out(k, cmd_m);
      if (k == TD) rdata_exp = sbyte;
      exp = {e, rdata_exp};
    end else begin
      exp = {5'b10000, rdata_exp};
    end
    chk("cycle", 32'(got), 32'(exp));
    if (done) begin
      ndone++;
      done_cyc      = cyc;
      rises_at_done = srises;
      mosi_at_done  = mosi_cap;
    end
    done_run = done ? done_run + 1 : 0;
    if (done_run == 2) done_wide++;
    if (cs_n) begin
      cs_run++;
    end else begin
      if (cs_run > 0) last_cs_run = cs_run;
      cs_run = 0;
    end
    if (cs_n) begin
      srises   = 0;
      mosi_cap = 8'h00;
      sbyte    = next_byte;
      miso     = 1'b0;
    end else begin
      if (sclk && !prev_sclk) begin
        if (srises < CW) mosi_cap = {mosi_cap[6:0], mosi};
        srises++;
      end
      if (!sclk && srises >= CW && srises < CW + DW)
        miso = sbyte[CW+DW-1-srises];
    end
    prev_sclk = sclk;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int n0, input string nm);
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (ndone != n0) break;
    end
    chk(nm, 32'(ndone != n0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] c, b;
    int acc, n0, w0, spur, dcyc, run, rises2, bad_hi, bad_lo;
    logic prev;
    rst_l = 1'b0; start = 1'b0; cmd = 8'h00;
    start2 = 1'b0; cmd2 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({cs_n, sclk, mosi, busy, done, rdata}),
        32'({5'b10000, 8'h00}));
    rst_l = 1'b1;
    tick(2);

    next_byte = 8'h3C; cmd = 8'hA5; start = 1'b1;
    acc = cyc; n0 = ndone;
    tick(1);
    start = 1'b0; cmd = 8'h00;
    wait_done(n0, "t1_done_seen");
    chk("t1_done_cycle", 32'(done_cyc - acc), 32'd137);
    chk("t1_sclk_rises", 32'(rises_at_done), 32'd16);
    chk("t1_mosi_bits", 32'(mosi_at_done), 32'hA5);
    chk("t1_rdata", 32'(rdata), 32'h3C);
    tick(3);

    b = 8'($urandom); next_byte = b;
    cmd = 8'h0F; start = 1'b1; n0 = ndone; w0 = done_wide;
    tick(300);
    start = 1'b0;
    chk("t2_two_dones", 32'(ndone - n0), 32'd2);
    chk("t2_cs_gap", 32'(last_cs_run), 32'd1);
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      tick(1);
    end
    chk("t2_drain", 32'(busy), 32'd0);
    chk("t2_done_width", 32'(done_wide - w0), 32'd0);
    chk("t2_rdata", 32'(rdata), 32'(b));
    tick(2);

    c = 8'($urandom); b = 8'($urandom); next_byte = b;
    cmd = c; start = 1'b1; acc = cyc; n0 = ndone;
    tick(1);
    start = 1'b0; cmd = ~c;
    tick(49);
    start = 1'b1; cmd = 8'hFF;
    tick(1);
    start = 1'b0;
    wait_done(n0, "t3_done_seen");
    chk("t3_done_cycle", 32'(done_cyc - acc), 32'd137);
    chk("t3_mosi_bits", 32'(mosi_at_done), 32'(c));
    chk("t3_rdata", 32'(rdata), 32'(b));
    tick(2);

    c = 8'($urandom); next_byte = 8'($urandom);
    cmd = c; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(69);
    rst_l = 1'b0;
    #1;
    chk("t4_async_reset", 32'({cs_n, sclk, busy, rdata}), 32'({3'b100, 8'h00}));
    n0 = ndone;
    tick(3);
    rst_l = 1'b1;
    tick(3);
    chk("t4_no_done", 32'(ndone - n0), 32'd0);
    c = 8'($urandom); b = 8'($urandom); next_byte = b;
    cmd = c; start = 1'b1; n0 = ndone;
    tick(1);
    start = 1'b0;
    wait_done(n0, "t4_restart_done");
    chk("t4_restart_rdata", 32'(rdata), 32'(b));
    chk("t4_restart_mosi", 32'(mosi_at_done), 32'(c));
    tick(2);

    for (int t = 0; t < 6; t++) begin
      c = 8'($urandom); b = 8'($urandom); next_byte = b;
      cmd = c; start = 1'b1; acc = cyc; n0 = ndone;
      tick(1);
      start = 1'b0; cmd = 8'($urandom);
      spur = $urandom_range(2, 130);
      tick(spur - 1);
      start = 1'b1; cmd = 8'hFF;
      tick(1);
      start = 1'b0;
      wait_done(n0, "rnd_done_seen");
      chk("rnd_done_cycle", 32'(done_cyc - acc), 32'd137);
      chk("rnd_rdata", 32'(rdata), 32'(b));
      tick($urandom_range(1, 5));
    end

    cmd2 = 8'h5A; start2 = 1'b1; acc = cyc;
    tick(1);
    start2 = 1'b0;
    dcyc = -1; run = 0; prev = 1'b0; rises2 = 0; bad_hi = 0; bad_lo = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done2) dcyc = cyc;
      if (sclk2 == prev) begin
        run++;
      end else begin
        if (prev) begin
          if (run != 2) bad_hi++;
        end else if (rises2 > 0) begin
          if (run != 2) bad_lo++;
        end
        if (sclk2) rises2++;
        run  = 1;
        prev = sclk2;
      end
    end
    chk("d2_done_cycle", 32'(dcyc - acc), 32'd69);
    chk("d2_rdata", 32'(rdata2), 32'hFF);
    chk("d2_rises", 32'(rises2), 32'd16);
    chk("d2_high_len", 32'(bad_hi), 32'd0);
    chk("d2_low_len", 32'(bad_lo), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
